// File: rtl/jt49_pkg.sv
// Shared JT49 noise definitions: LFSR geometry, feedback taps and the
// checker state encoding. The noise generator and the checker both import
// this package so the polynomial is defined in exactly one place.
package jt49_pkg;

  localparam int LFSR_LEN = 17;
  localparam int TAP_A    = 0;
  localparam int TAP_B    = 3;

  typedef enum logic [1:0] {
    NS_ACQ    = 2'd0,
    NS_VERIFY = 2'd1,
    NS_LOCK   = 2'd2
  } noise_state_t;

  // Generator feedback: two taps plus the all-zero escape that keeps the
  // register from sticking at zero.
  function automatic logic lfsr_feedback(input logic [LFSR_LEN-1:0] r);
    return r[TAP_A] ^ r[TAP_B] ^ (r == '0);
  endfunction

endpackage

// File: rtl/jt49_noise_chk.sv
// Noise stream checker: rebuilds the last 17 noise bits in a window, predicts
// each next bit with the PSG polynomial, and reports lock / mismatch status.
module jt49_noise_chk
  import jt49_pkg::*;
#(
  parameter int unsigned LOCK_N = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       sample,
  input  logic       noise_in,
  input  logic       clear,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [4:0] FILL_LAST  = 5'(LFSR_LEN - 1);
  localparam logic [7:0] MATCH_LAST = 8'(LOCK_N - 1);

  noise_state_t          state, state_nxt;
  logic [LFSR_LEN-1:0]   win, win_nxt;
  logic [4:0]            fill, fill_nxt;
  logic [7:0]            match, match_nxt;
  logic [7:0]            err_cnt_nxt;
  logic                  err_nxt;
  logic                  locked_nxt;

  logic                  accept;
  logic                  bit_in;
  logic                  hit;

  // The observed pin carries the inverted LFSR bit; clear wins over sample.
  assign accept = cen & sample & ~clear;
  assign bit_in = ~noise_in;
  // Prediction always uses the window as it stood before this bit shifts in.
  assign hit    = (bit_in == lfsr_feedback(win));

  // Next-state and next-output decode for the acquire / verify / lock FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    win_nxt     = win;
    fill_nxt    = fill;
    match_nxt   = match;
    err_cnt_nxt = err_cnt;
    err_nxt     = 1'b0;

    if (cen && clear) begin
      state_nxt   = NS_ACQ;
      win_nxt     = '0;
      fill_nxt    = '0;
      match_nxt   = '0;
      err_cnt_nxt = '0;
    end else if (accept) begin
      win_nxt = {bit_in, win[LFSR_LEN-1:1]};
      case (state)
        NS_ACQ: begin
          if (fill == FILL_LAST) begin
            state_nxt = NS_VERIFY;
            fill_nxt  = '0;
            match_nxt = '0;
          end else begin
            fill_nxt = fill + 5'd1;
          end
        end
        NS_VERIFY: begin
          if (hit) begin
            match_nxt = match + 8'd1;
            if (match == MATCH_LAST) state_nxt = NS_LOCK;
          end else begin
            match_nxt = '0;
          end
        end
        NS_LOCK: begin
          if (!hit) begin
            err_nxt   = 1'b1;
            state_nxt = NS_ACQ;
            fill_nxt  = '0;
            match_nxt = '0;
            if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
          end
        end
        default: begin
          state_nxt = NS_ACQ;
          fill_nxt  = '0;
          match_nxt = '0;
        end
      endcase
    end

    locked_nxt = (state_nxt == NS_LOCK);
  end

  // State, window, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= NS_ACQ;
      win     <= '0;
      fill    <= '0;
      match   <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state   <= state_nxt;
      win     <= win_nxt;
      fill    <= fill_nxt;
      match   <= match_nxt;
      locked  <= locked_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_jt49_noise_chk.sv
// Directed bench for jt49_noise_chk: a reference PSG noise generator feeds
// the checker and each scenario compares against hand-derived latencies.
module tb_jt49_noise_chk;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic       sample;
  logic       noise_in;
  logic       clear;
  logic       locked,  err;
  logic [7:0] err_cnt;
  logic       locked1, err1;
  logic [7:0] err_cnt1;

  int vectors;
  int miscompares;

  logic [16:0] gen;

  jt49_noise_chk #(.LOCK_N(17)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sample(sample),
    .noise_in(noise_in), .clear(clear),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  jt49_noise_chk #(.LOCK_N(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sample(sample),
    .noise_in(noise_in), .clear(clear),
    .locked(locked1), .err(err1), .err_cnt(err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference PSG generator: shift right, feedback into bit 16, emit bit 0.
  task automatic gen_bit(output logic b);
    logic fb;
    fb  = gen[0] ^ gen[3] ^ (gen == 17'd0);
    gen = {fb, gen[16:1]};
    b   = gen[0];
  endtask

  // One accepted bit: drive on the falling edge, outputs valid #1 after rise.
  task automatic feed(input logic b);
    @(negedge clk);
    cen = 1'b1; sample = 1'b1; clear = 1'b0; noise_in = ~b;
    @(posedge clk);
    #1;
    cen = 1'b0; sample = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cen = 1'b0; sample = 1'b0; clear = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    vectors += 6;
    if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    if (locked1 !== 1'b0) begin miscompares++; $display("FAIL reset_locked_n1: got %b want 0", locked1); end
    if (err1 !== 1'b0) begin miscompares++; $display("FAIL reset_err_n1: got %b want 0", err1); end
    if (err_cnt1 !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt_n1: got %0d want 0", err_cnt1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Lock from a zero-seeded generator: 17 fill bits plus 17 verified bits.
  task automatic test_lock_zero_seed;
    logic b;
    gen = '0;
    for (int i = 1; i <= 34; i++) begin
      gen_bit(b);
      feed(b);
      vectors += 2;
      if (locked !== 1'(i == 34)) begin
        miscompares++; $display("FAIL lock_zero_locked bit %0d: got %b want %b", i, locked, (i == 34));
      end
      if (err !== 1'b0) begin miscompares++; $display("FAIL lock_zero_err bit %0d: got %b want 0", i, err); end
    end
    vectors++;
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL lock_zero_err_cnt: got %0d want 0", err_cnt); end
  endtask

  // Bit 50 inverted: one-clock err, count 1, drop lock, relock on bit 84.
  task automatic test_single_error;
    logic b;
    for (int i = 35; i <= 84; i++) begin
      gen_bit(b);
      feed((i == 50) ? ~b : b);
      vectors += 3;
      if (locked !== 1'((i < 50) || (i >= 84))) begin
        miscompares++; $display("FAIL single_err_locked bit %0d: got %b want %b", i, locked, ((i < 50) || (i >= 84)));
      end
      if (err !== 1'(i == 50)) begin
        miscompares++; $display("FAIL single_err_err bit %0d: got %b want %b", i, err, (i == 50));
      end
      if (err_cnt !== ((i >= 50) ? 8'd1 : 8'd0)) begin
        miscompares++; $display("FAIL single_err_cnt bit %0d: got %0d want %0d", i, err_cnt, (i >= 50) ? 1 : 0);
      end
    end
    idle(1);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL single_err_pulse_end: got %b want 0", err); end
  endtask

  // Non-accepted cycles (cen=0 with sample/clear, or sample=0) change nothing.
  task automatic test_gating;
    logic b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cen = 1'b0; sample = 1'b1; noise_in = 1'($urandom); clear = 1'(i % 7 == 0);
      @(posedge clk);
      #1;
      vectors += 2;
      if (locked !== 1'b1) begin miscompares++; $display("FAIL gate_cen_locked clk %0d: got %b want 1", i, locked); end
      if (err !== 1'b0) begin miscompares++; $display("FAIL gate_cen_err clk %0d: got %b want 0", i, err); end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cen = 1'b1; sample = 1'b0; clear = 1'b0; noise_in = 1'($urandom);
      @(posedge clk);
      #1;
      vectors += 2;
      if (locked !== 1'b1) begin miscompares++; $display("FAIL gate_smp_locked clk %0d: got %b want 1", i, locked); end
      if (err !== 1'b0) begin miscompares++; $display("FAIL gate_smp_err clk %0d: got %b want 0", i, err); end
    end
    cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gen_bit(b);
      feed(b);
      vectors += 2;
      if (locked !== 1'b1) begin miscompares++; $display("FAIL gate_resume_locked bit %0d: got %b want 1", i, locked); end
      if (err !== 1'b0) begin miscompares++; $display("FAIL gate_resume_err bit %0d: got %b want 0", i, err); end
    end
    vectors++;
    if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL gate_err_cnt: got %0d want 1", err_cnt); end
  endtask

  // Asynchronous reset mid-lock, then relock with a gated gap inside ACQ.
  task automatic test_async_reset;
    logic b;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (locked !== 1'b0) begin miscompares++; $display("FAIL async_rst_locked: got %b want 0", locked); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL async_rst_err: got %b want 0", err); end
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL async_rst_err_cnt: got %0d want 0", err_cnt); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    gen = '0;
    for (int i = 1; i <= 34; i++) begin
      if (i == 11) begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          cen = 1'b0; sample = 1'b1; noise_in = 1'($urandom);
          @(posedge clk);
        end
      end
      gen_bit(b);
      feed(b);
      vectors++;
      if (locked !== 1'(i == 34)) begin
        miscompares++; $display("FAIL async_relock bit %0d: got %b want %b", i, locked, (i == 34));
      end
    end
  endtask

  // clear together with a bad sample while locked: reset wins, no err.
  task automatic test_clear;
    logic b;
    gen_bit(b);
    feed(~b);
    vectors += 2;
    if (err !== 1'b1) begin miscompares++; $display("FAIL clear_pre_err: got %b want 1", err); end
    if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL clear_pre_cnt: got %0d want 1", err_cnt); end
    for (int i = 1; i <= 34; i++) begin
      gen_bit(b);
      feed(b);
    end
    vectors++;
    if (locked !== 1'b1) begin miscompares++; $display("FAIL clear_pre_locked: got %b want 1", locked); end
    gen_bit(b);
    @(negedge clk);
    cen = 1'b1; sample = 1'b1; clear = 1'b1; noise_in = b;
    @(posedge clk);
    #1;
    cen = 1'b0; sample = 1'b0; clear = 1'b0;
    vectors += 3;
    if (locked !== 1'b0) begin miscompares++; $display("FAIL clear_locked: got %b want 0", locked); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL clear_err: got %b want 0", err); end
    if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL clear_err_cnt: got %0d want 0", err_cnt); end
    gen = '0;
    for (int i = 1; i <= 34; i++) begin
      gen_bit(b);
      feed(b);
      vectors++;
      if (locked !== 1'(i == 34)) begin
        miscompares++; $display("FAIL clear_relock bit %0d: got %b want %b", i, locked, (i == 34));
      end
    end
  endtask

  // LOCK_N=1 instance: 300 lock/error rounds of 17 fill + 1 verify + 1 bad.
  task automatic test_saturation;
    logic b;
    logic [7:0] want_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    gen = '0;
    for (int k = 1; k <= 300; k++) begin
      for (int i = 0; i < 18; i++) begin
        gen_bit(b);
        feed(b);
      end
      vectors += 2;
      if (locked1 !== 1'b1) begin miscompares++; $display("FAIL sat_locked round %0d: got %b want 1", k, locked1); end
      if (err1 !== 1'b0) begin miscompares++; $display("FAIL sat_err_low round %0d: got %b want 0", k, err1); end
      gen_bit(b);
      feed(~b);
      want_cnt = (k >= 255) ? 8'd255 : 8'(k);
      vectors += 3;
      if (err1 !== 1'b1) begin miscompares++; $display("FAIL sat_err_pulse round %0d: got %b want 1", k, err1); end
      if (err_cnt1 !== want_cnt) begin
        miscompares++; $display("FAIL sat_err_cnt round %0d: got %0d want %0d", k, err_cnt1, want_cnt);
      end
      if (locked1 !== 1'b0) begin miscompares++; $display("FAIL sat_unlock round %0d: got %b want 0", k, locked1); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cen         = 1'b0;
    sample      = 1'b0;
    noise_in    = 1'b1;
    clear       = 1'b0;
    gen         = '0;

    test_reset();
    test_lock_zero_seed();
    test_single_error();
    test_gating();
    test_async_reset();
    test_clear();
    test_saturation();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
